alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, sequential successor to the mc6502 combinational ALU.
- Same operation set and flag-byte layout, generalised to WIDTH bits.
- Adds a START/BUSY/DONE handshake, registered outputs, binary overflow (V) for ADC/SBC, and decimal-mode ADC/SBC.
- Decimal ADC/SBC is processed one BCD digit per cycle. It sits between the mc6502 datapath sequencer and the register file/P register.

Parameters:
- WIDTH, 8, operand/result width in bits; multiple of 4, minimum 8.
- NDIG, WIDTH/4, number of BCD digits; derived, not to be overridden.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset; synchronous and active-high.
- START  input  1  request; accepted only in IDLE.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CTRL  input  4  operation; values match the C_ALU_CTRL_* constants: 0 THA, 1 INC, 2 DEC, 3 ASL, 4 LSR, 5 ROL, 6 ROR, 7 AND, 8 ORA, 9 EOR, A ADC, B SBC, C CMP, D BIT, E/F treated as THA.
- FLAG_IN  input  8  P register; bit 7 N, 6 V, 5 unused, 4 B, 3 D, 2 I, 1 Z, 0 C.
- BUSY  output  1  high whenever the state is not IDLE.
- DONE  output  1  one-cycle pulse; OUT/FLAG_OUT are valid.
- OUT  output  WIDTH  registered result; held until the next accepted START completes.
- FLAG_OUT  output  8  registered flags, same layout as FLAG_IN.

Behaviour:
- Reset: RST=1 at a clock edge → state IDLE, BUSY=0, DONE=0, OUT=0, FLAG_OUT=0, digit counter=0.
  - RST has priority over START and aborts any operation in flight; no DONE is produced for an aborted operation.
- States:
  - IDLE: START=1 captures A, B, CTRL, FLAG_IN. Go to DEC if CTRL∈{ADC,SBC} and FLAG_IN[3]=1, else go to BIN.
  - BIN: compute, register OUT/FLAG_OUT, go to FIN.
  - DEC: process digit k (k=0 is the least significant), k counts 0..NDIG-1. Register the digit into OUT[4k+3:4k] and the carry into an internal register. After k=NDIG-1, register the flags and go to FIN.
  - FIN: DONE=1, then go to IDLE.
- START while BUSY (including FIN) is ignored; the next START can be accepted in the cycle after DONE.
- Latency: START sampled at edge t → DONE high in cycle t+2 for non-decimal operations, t+NDIG+2 for decimal operations. BUSY is high from t+1 through the DONE cycle inclusive.
- Flags: bits 5, 4, 3, 2 are always copied from the captured FLAG_IN. Unaffected N/V/Z/C bits pass through unchanged.
- Binary operations (M = WIDTH-1):
  - THA: OUT=A.
  - INC/DEC: OUT=A±1, modulo 2^WIDTH.
  - ASL: C=A[M].
  - LSR: C=A[0].
  - ROL: OUT={A[M-1:0],C}, C=A[M].
  - ROR: OUT={C,A[M:1]}, C=A[0].
  - AND, ORA, EOR: bitwise.
  - ADC: {C,OUT}=A+B+C.
  - SBC: {C,OUT}=A+~B+C, so C=1 means no borrow.
  - ADC/SBC set V = signed overflow of that binary sum.
  - N=OUT[M], Z=(OUT==0) for every operation except CMP and BIT.
  - CMP: OUT=A (unchanged). C=(A>=B) unsigned, Z=(A==B), N=(A-B)[M].
  - BIT: OUT=A. N=B[M], V=B[M-1], Z=((A&B)==0).
- Decimal ADC, per digit: s=a+b+c. If s>9 then s=s+6 and cout=1, else cout=0. digit=s[3:0]. Initial c=FLAG_IN C.
- Decimal SBC, per digit: d=a-b-(1-c). If d<0 then d=d+10 and cout=0, else cout=1. digit=d[3:0].
- Decimal flags:
  - C = carry out of the final digit.
  - N, Z come from the final decimal OUT.
  - V = binary-mode V for the same operands.
- Non-BCD digits (>9) are not errors; the result is exactly as given by the algorithm above.

Test Plan:
- WIDTH=8, D=0, ADC A=0x50 B=0x50 C=0, START at t → DONE at t+2, OUT=0xA0, N=1 V=1 Z=0 C=0; bits 5..2 equal FLAG_IN.
- WIDTH=8, D=1, ADC A=0x58 B=0x46 C=1 → OUT=0x05, C=1, Z=0, N=0; BUSY high t+1..t+4, DONE at t+4.
- WIDTH=8, D=1, SBC A=0x12 B=0x21 C=1 → OUT=0x91, C=0, N=1; then SBC A=0x46 B=0x12 C=1 → OUT=0x34, C=1.
- Shifts: LSR 0x01 → OUT=0x00, Z=1, C=1. ROR 0x01 with C=1 → OUT=0x80, N=1, C=1. CMP A=0x10 B=0x10 → OUT=0x10, Z=1, C=1. BIT A=0x0F B=0xC0 → N=1 V=1 Z=1.
- Handshake/reset: START during a decimal op is ignored (one DONE only, with the first operands). RST asserted mid-DEC → next cycle BUSY=0, OUT=0, FLAG_OUT=0, and no DONE follows.
- WIDTH=16, D=1, ADC A=0x9999 B=0x0001 C=0 → OUT=0x0000, C=1, Z=1, DONE at t+6.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential mc6502-style ALU with START/BUSY/DONE handshake
// Binary ops take one compute cycle; decimal ADC/SBC walk one BCD digit per cycle.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int NDIG  = WIDTH / 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       CTRL,
   input  logic [7:0]       FLAG_IN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] OUT,
   output logic [7:0]       FLAG_OUT
);

   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(NDIG + 1);
   localparam logic [CW-1:0] LAST = CW'(NDIG);

   localparam logic [3:0] C_INC = 4'h1;
   localparam logic [3:0] C_DEC = 4'h2;
   localparam logic [3:0] C_ASL = 4'h3;
   localparam logic [3:0] C_LSR = 4'h4;
   localparam logic [3:0] C_ROL = 4'h5;
   localparam logic [3:0] C_ROR = 4'h6;
   localparam logic [3:0] C_AND = 4'h7;
   localparam logic [3:0] C_ORA = 4'h8;
   localparam logic [3:0] C_EOR = 4'h9;
   localparam logic [3:0] C_ADC = 4'hA;
   localparam logic [3:0] C_SBC = 4'hB;
   localparam logic [3:0] C_CMP = 4'hC;
   localparam logic [3:0] C_BIT = 4'hD;

   typedef enum logic [1:0] {S_IDLE, S_BIN, S_DEC, S_FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [7:0]       flag_q, flag_d, flag_out_q, flag_out_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dc_q, dc_d, done_q, done_d, busy_q, busy_d;

   logic [WIDTH-1:0] bop, bin_out;
   logic [WIDTH:0]   sum, cmp_diff;
   logic             bin_v, bin_n, bin_vf, bin_z, bin_c;
   logic [3:0]       a_dig, b_dig, dig;
   logic [4:0]       s, d;
   logic             dig_c;
   logic             unused_flags;

   // N and Z of the incoming P register are always recomputed, never passed through.
   assign unused_flags = flag_q[7] ^ flag_q[1];

   assign bop      = (ctrl_q == C_SBC) ? ~b_q : b_q;
   assign sum      = {1'b0, a_q} + {1'b0, bop} + {{WIDTH{1'b0}}, flag_q[0]};
   assign cmp_diff = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
   assign bin_v    = (a_q[M] == bop[M]) && (sum[M] != a_q[M]);

   always_comb begin
      bin_out = a_q;
      bin_c   = flag_q[0];
      bin_vf  = flag_q[6];
      case (ctrl_q)
         C_INC: bin_out = a_q + WIDTH'(1);
         C_DEC: bin_out = a_q - WIDTH'(1);
         C_ASL: begin bin_out = {a_q[M-1:0], 1'b0};      bin_c = a_q[M]; end
         C_LSR: begin bin_out = {1'b0, a_q[M:1]};        bin_c = a_q[0]; end
         C_ROL: begin bin_out = {a_q[M-1:0], flag_q[0]}; bin_c = a_q[M]; end
         C_ROR: begin bin_out = {flag_q[0], a_q[M:1]};   bin_c = a_q[0]; end
         C_AND: bin_out = a_q & b_q;
         C_ORA: bin_out = a_q | b_q;
         C_EOR: bin_out = a_q ^ b_q;
         C_ADC, C_SBC: begin
            bin_out = sum[M:0];
            bin_c   = sum[WIDTH];
            bin_vf  = bin_v;
         end
         C_CMP: bin_c = cmp_diff[WIDTH];
         default: ;
      endcase
      bin_n = bin_out[M];
      bin_z = (bin_out == '0);
      if (ctrl_q == C_CMP) begin
         bin_n = cmp_diff[M];
         bin_z = (a_q == b_q);
      end else if (ctrl_q == C_BIT) begin
         bin_n  = b_q[M];
         bin_vf = b_q[M-1];
         bin_z  = ((a_q & b_q) == '0);
      end
   end

   // One BCD digit step; the +6/+10 corrections only matter modulo 16.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int k = 0; k < NDIG; k++) begin
         if (cnt_q == CW'(k)) begin
            a_dig = a_q[4*k +: 4];
            b_dig = b_q[4*k +: 4];
         end
      end
      s = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, dc_q};
      d = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0, ~dc_q};
      if (ctrl_q == C_SBC) begin
         dig_c = ~d[4];
         dig   = d[4] ? d[3:0] + 4'd10 : d[3:0];
      end else begin
         dig_c = (s > 5'd9);
         dig   = dig_c ? s[3:0] + 4'd6 : s[3:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      ctrl_d     = ctrl_q;
      flag_d     = flag_q;
      cnt_d      = cnt_q;
      dc_d       = dc_q;
      out_d      = out_q;
      flag_out_d = flag_out_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: if (START) begin
            a_d     = A;
            b_d     = B;
            ctrl_d  = CTRL;
            flag_d  = FLAG_IN;
            cnt_d   = '0;
            dc_d    = FLAG_IN[0];
            state_d = ((CTRL == C_ADC || CTRL == C_SBC) && FLAG_IN[3]) ? S_DEC : S_BIN;
         end
         S_BIN: begin
            out_d      = bin_out;
            flag_out_d = {bin_n, bin_vf, flag_q[5:2], bin_z, bin_c};
            done_d     = 1'b1;
            state_d    = S_FIN;
         end
         S_DEC: if (cnt_q == LAST) begin
            flag_out_d = {out_q[M], bin_v, flag_q[5:2], (out_q == '0), dc_q};
            done_d     = 1'b1;
            state_d    = S_FIN;
         end else begin
            for (int k = 0; k < NDIG; k++) begin
               if (cnt_q == CW'(k)) out_d[4*k +: 4] = dig;
            end
            dc_d  = dig_c;
            cnt_d = cnt_q + CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         ctrl_q     <= '0;
         flag_q     <= '0;
         cnt_q      <= '0;
         dc_q       <= 1'b0;
         out_q      <= '0;
         flag_out_q <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         ctrl_q     <= ctrl_d;
         flag_q     <= flag_d;
         cnt_q      <= cnt_d;
         dc_q       <= dc_d;
         out_q      <= out_d;
         flag_out_q <= flag_out_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign OUT      = out_q;
   assign FLAG_OUT = flag_out_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - bench for alu_seq: vector table, random ops vs. reference model
// Runs an 8-bit and a 16-bit instance side by side on one clock and reset.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start16;
   logic [15:0] a_in, b_in;
   logic [3:0]  ctrl_in;
   logic [7:0]  flag_in;
   logic        busy8, done8, busy16, done16;
   logic [7:0]  out8, fl8, fl16;
   logic [15:0] out16;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut8 (
      .CLK(clk), .RST(rst), .START(start8), .A(a_in[7:0]), .B(b_in[7:0]),
      .CTRL(ctrl_in), .FLAG_IN(flag_in), .BUSY(busy8), .DONE(done8),
      .OUT(out8), .FLAG_OUT(fl8)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .CLK(clk), .RST(rst), .START(start16), .A(a_in), .B(b_in),
      .CTRL(ctrl_in), .FLAG_IN(flag_in), .BUSY(busy16), .DONE(done16),
      .OUT(out16), .FLAG_OUT(fl16)
   );

   typedef struct {
      logic [3:0] ctrl;
      int a, b, f;
      int out, fl, lat;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation rules.
   function automatic void model(input int w, input int ctrl, input int a, input int b,
                                 input int f, output int out, output int fl, output int lat);
      int m, msb, n, v, z, c, cin, bb, s, sv, sa, sb, cc, res, da, db, t;
      m   = (1 << w) - 1;
      msb = 1 << (w - 1);
      cin = f & 1;
      v   = (f >> 6) & 1;
      c   = cin;
      out = a;
      lat = 2;
      case (ctrl)
         1:  out = (a + 1) & m;
         2:  out = (a + m) & m;
         3:  begin out = (a * 2) & m; c = (a >= msb); end
         4:  begin out = a / 2; c = a % 2; end
         5:  begin out = (a * 2 + cin) & m; c = (a >= msb); end
         6:  begin out = a / 2 + cin * msb; c = a % 2; end
         7:  out = a & b;
         8:  out = a | b;
         9:  out = a ^ b;
         10, 11: begin
            bb  = (ctrl == 10) ? b : m - b;
            s   = a + bb + cin;
            out = s & m;
            c   = (s > m) ? 1 : 0;
            sa  = (a >= msb) ? a - 2 * msb : a;
            sb  = (bb >= msb) ? bb - 2 * msb : bb;
            sv  = sa + sb + cin;
            v   = (sv < -msb || sv > msb - 1) ? 1 : 0;
            if ((f >> 3) & 1) begin
               lat = w / 4 + 2;
               cc  = cin;
               res = 0;
               for (int k = 0; k < w / 4; k++) begin
                  da = (a >> (4 * k)) & 15;
                  db = (b >> (4 * k)) & 15;
                  if (ctrl == 10) begin
                     t = da + db + cc;
                     if (t > 9) begin t = t + 6; cc = 1; end else cc = 0;
                  end else begin
                     t = da - db - (1 - cc);
                     if (t < 0) begin t = t + 10; cc = 0; end else cc = 1;
                  end
                  res = res | ((t & 15) << (4 * k));
               end
               out = res;
               c   = cc;
            end
         end
         default: ;
      endcase
      n = (out >= msb) ? 1 : 0;
      z = (out == 0) ? 1 : 0;
      if (ctrl == 12) begin
         c = (a >= b) ? 1 : 0;
         z = (a == b) ? 1 : 0;
         n = (((a - b) & m) >= msb) ? 1 : 0;
      end else if (ctrl == 13) begin
         n = (b >= msb) ? 1 : 0;
         v = (b >> (w - 2)) & 1;
         z = ((a & b) == 0) ? 1 : 0;
      end
      fl = (n << 7) | (v << 6) | (f & 'h3C) | (z << 1) | c;
   endfunction

   // Issue one operation and wait for DONE; lat is cycles from the START edge, -1 on timeout.
   task automatic run_op(input bit wide, input logic [3:0] ctrl, input int a, input int b,
                         input int f, output int out, output int fl, output int lat,
                         output int busy_cnt);
      @(negedge clk);
      a_in    = a[15:0];
      b_in    = b[15:0];
      ctrl_in = ctrl;
      flag_in = f[7:0];
      if (wide) start16 = 1'b1; else start8 = 1'b1;
      lat = -1;
      busy_cnt = 0;
      out = 0;
      fl = 0;
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         @(negedge clk);
         start8  = 1'b0;
         start16 = 1'b0;
         if (wide ? busy16 : busy8) busy_cnt++;
         if (wide ? done16 : done8) begin
            lat = i;
            out = wide ? int'(out16) : int'(out8);
            fl  = wide ? int'(fl16) : int'(fl8);
         end
      end
   endtask

   initial begin
      int out, fl, lat, bc, e_out, e_fl, e_lat, a, b, f, ctrl, dones, w;

      tbl[0]  = '{4'hA, 'h50, 'h50, 'h34, 'hA0, 'hF4, 2};
      tbl[1]  = '{4'hA, 'h58, 'h46, 'h09, 'h05, 'h49, 4};
      tbl[2]  = '{4'hB, 'h12, 'h21, 'h09, 'h91, 'h88, 4};
      tbl[3]  = '{4'hB, 'h46, 'h12, 'h09, 'h34, 'h09, 4};
      tbl[4]  = '{4'h4, 'h01, 'h00, 'h00, 'h00, 'h03, 2};
      tbl[5]  = '{4'h6, 'h01, 'h00, 'h01, 'h80, 'h81, 2};
      tbl[6]  = '{4'hC, 'h10, 'h10, 'h00, 'h10, 'h03, 2};
      tbl[7]  = '{4'hD, 'h0F, 'hC0, 'h00, 'h0F, 'hC2, 2};
      tbl[8]  = '{4'hF, 'h7F, 'h00, 'h08, 'h7F, 'h08, 2};
      tbl[9]  = '{4'h1, 'hFF, 'h00, 'hC1, 'h00, 'h43, 2};
      tbl[10] = '{4'h2, 'h00, 'h00, 'h00, 'hFF, 'h80, 2};
      tbl[11] = '{4'h3, 'h81, 'h00, 'h00, 'h02, 'h01, 2};
      tbl[12] = '{4'h5, 'h80, 'h00, 'h01, 'h01, 'h01, 2};
      tbl[13] = '{4'h9, 'hFF, 'hFF, 'h40, 'h00, 'h42, 2};
      tbl[14] = '{4'hB, 'h80, 'h01, 'h01, 'h7F, 'h41, 2};
      tbl[15] = '{4'hC, 'h01, 'h02, 'h00, 'h01, 'h80, 2};

      rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
      a_in = '0; b_in = '0; ctrl_in = '0; flag_in = '0;
      repeat (2) @(negedge clk);
      chk("reset busy8", busy8, 0);
      chk("reset done8", done8, 0);
      chk("reset out8", out8, 0);
      chk("reset flag8", fl8, 0);
      chk("reset busy16", busy16, 0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_op(1'b0, tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].f, out, fl, lat, bc);
         chk($sformatf("vec%0d out", i), out, tbl[i].out);
         chk($sformatf("vec%0d flags", i), fl, tbl[i].fl);
         chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d busy cycles", i), bc, tbl[i].lat);
      end

      run_op(1'b1, 4'hA, 'h9999, 'h0001, 'h08, out, fl, lat, bc);
      chk("w16 dec adc out", out, 'h0000);
      chk("w16 dec adc flags", fl, 'h0B);
      chk("w16 dec adc latency", lat, 6);

      // START held during a decimal op must not start a second one.
      @(negedge clk);
      a_in = 16'h58; b_in = 16'h46; ctrl_in = 4'hA; flag_in = 8'h09; start8 = 1'b1;
      dones = 0; out = -1; lat = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) begin a_in = 16'h11; b_in = 16'h22; flag_in = 8'h01; end
         if (i == 4) start8 = 1'b0;
         if (done8) begin
            dones++;
            out = out8;
            lat = i;
         end
      end
      chk("busy start dones", dones, 1);
      chk("busy start out", out, 'h05);
      chk("busy start latency", lat, 4);

      // Reset in the middle of a decimal op aborts it silently.
      @(negedge clk);
      a_in = 16'h99; b_in = 16'h99; ctrl_in = 4'hA; flag_in = 8'h09; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort busy", busy8, 0);
      chk("abort out", out8, 0);
      chk("abort flags", fl8, 0);
      rst = 1'b0;
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (done8) dones++;
      end
      chk("abort no done", dones, 0);

      for (int i = 0; i < 200; i++) begin
         w    = (i % 5 == 4) ? 16 : 8;
         ctrl = (i % 3 == 0) ? 10 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
         a    = int'($urandom & ((1 << w) - 1));
         b    = int'($urandom & ((1 << w) - 1));
         f    = int'($urandom & 'hFF);
         model(w, ctrl, a, b, f, e_out, e_fl, e_lat);
         run_op(w == 16, ctrl[3:0], a, b, f, out, fl, lat, bc);
         chk($sformatf("rnd%0d w%0d op%0h a%0h b%0h f%0h out", i, w, ctrl, a, b, f), out, e_out);
         chk($sformatf("rnd%0d w%0d op%0h a%0h b%0h f%0h flags", i, w, ctrl, a, b, f), fl, e_fl);
         chk($sformatf("rnd%0d latency", i), lat, e_lat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
